fp_norm_sequencer: RTL



---
 rtl/fp_norm_pkg.sv | 9 +
 rtl/fp_norm_sequencer_if.sv | 27 ++
 rtl/fp_norm_step.sv | 23 ++
 rtl/fp_norm_sequencer.sv | 58 +++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared state encoding, default widths and step condition for the normalizer
package fp_norm_pkg;
  localparam int M_DEF = 24;
  localparam int E_DEF = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic step_cond(input logic exp_nz, input logic msb, input logic mant_nz);
    return exp_nz && !msb && mant_nz;
  endfunction
endpackage

// File: rtl/fp_norm_sequencer_if.sv
// fp_norm_sequencer_if: input/output handshakes of the normalizer; master drives requests, slave is the normalizer
interface fp_norm_sequencer_if
  import fp_norm_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int E = E_DEF
);
  localparam int CW = $clog2(M);
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_mant;
  logic [E-1:0]  in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_mant;
  logic [E-1:0]  out_exp;
  logic [CW-1:0] out_shift_count;
  logic          busy;
  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_shift_count, busy
  );
  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_shift_count, busy
  );
endinterface

// File: rtl/fp_norm_step.sv
// fp_norm_step: one conditional single-bit left shift with exponent decrement and count increment
module fp_norm_step
  import fp_norm_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int E = E_DEF,
  parameter int CW = $clog2(M)
) (
  input  logic [M-1:0]  mant,
  input  logic [E-1:0]  exp,
  input  logic [CW-1:0] cnt,
  output logic          c,
  output logic [M-1:0]  nmant,
  output logic [E-1:0]  nexp,
  output logic [CW-1:0] ncnt
);
  always_comb begin
    c     = step_cond(exp != '0, mant[M-1], mant != '0);
    nmant = c ? mant << 1 : mant;
    nexp  = c ? exp - E'(1) : exp;
    ncnt  = c ? cnt + CW'(1) : cnt;
  end
endmodule

// File: rtl/fp_norm_sequencer.sv
// fp_norm_sequencer: iterative mantissa normalizer, one shift per clock until MSB set, exp zero or mantissa zero
// Optional FP_NORM_FASTPATH_EN: pairs needing no shift skip SHIFT and go straight to DONE.
module fp_norm_sequencer
  import fp_norm_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int E = E_DEF,
  localparam int CW = $clog2(M)
) (
  input logic clk,
  input logic rst,
  fp_norm_sequencer_if.slave bus
);
  state_t        state, nstate, load_state;
  logic [M-1:0]  mant, nmant;
  logic [E-1:0]  exp, nexp;
  logic [CW-1:0] cnt, ncnt;
  logic          c;
  fp_norm_step #(.M(M), .E(E), .CW(CW)) u_step (
    .mant(mant), .exp(exp), .cnt(cnt), .c(c), .nmant(nmant), .nexp(nexp), .ncnt(ncnt)
  );
`ifdef FP_NORM_FASTPATH_EN
  assign load_state = step_cond(bus.in_exp != '0, bus.in_mant[M-1], bus.in_mant != '0) ? SHIFT : DONE;
`else
  assign load_state = SHIFT;
`endif
  always_comb begin
    nstate = state;
    nstate = state == IDLE  ? (bus.in_valid ? load_state : IDLE) :
             state == SHIFT ? (c ? SHIFT : DONE) :
                              (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mant  <= '0;
      exp   <= '0;
      cnt   <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && bus.in_valid) begin
        mant <= bus.in_mant;
        exp  <= bus.in_exp;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        mant <= nmant;
        exp  <= nexp;
        cnt  <= ncnt;
      end
    end
  end
  assign bus.in_ready        = state == IDLE && !rst;
  assign bus.busy            = state != IDLE;
  assign bus.out_valid       = state == DONE;
  assign bus.out_mant        = mant;
  assign bus.out_exp         = exp;
  assign bus.out_shift_count = cnt;
endmodule
